// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - glyph and code constants for the seven-segment scan driver
// Purpose: shared active-low segment patterns {a,b,c,d,e,f,g,dp} and glyph codes.
// Ports: none (package).
package ssd_pkg;

    localparam logic [7:0] SS_0     = 8'h03;
    localparam logic [7:0] SS_1     = 8'h9F;
    localparam logic [7:0] SS_2     = 8'h25;
    localparam logic [7:0] SS_3     = 8'h0D;
    localparam logic [7:0] SS_4     = 8'h99;
    localparam logic [7:0] SS_5     = 8'h49;
    localparam logic [7:0] SS_6     = 8'h41;
    localparam logic [7:0] SS_7     = 8'h1F;
    localparam logic [7:0] SS_8     = 8'h01;
    localparam logic [7:0] SS_9     = 8'h09;
    localparam logic [7:0] SS_A     = 8'h11;
    localparam logic [7:0] SS_MINUS = 8'hFD;
    localparam logic [7:0] SS_M     = 8'h91;
    localparam logic [7:0] SS_F     = 8'h71;
    localparam logic [7:0] SS_BLANK = 8'hFF;

    localparam logic [3:0] CODE_A     = 4'd10;
    localparam logic [3:0] CODE_MINUS = 4'd11;
    localparam logic [3:0] CODE_M     = 4'd12;
    localparam logic [3:0] CODE_F     = 4'd13;
    localparam logic [3:0] CODE_BLANK = 4'd15;

endpackage

// File: rtl/ssd_scan_display_glyph_decode.sv
// rtl/ssd_scan_display_glyph_decode.sv - combinational glyph code to segment pattern
// Purpose: map a 4-bit glyph code plus decimal point to an active-low segment byte.
// Ports: code (4-bit glyph), dp (decimal point request), seg (8-bit {a..g,dp}, active-low).
module ssd_glyph_decode
    import ssd_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [7:0] base;

    always_comb begin
        base = SS_BLANK;
        case (code)
            4'd0:       base = SS_0;
            4'd1:       base = SS_1;
            4'd2:       base = SS_2;
            4'd3:       base = SS_3;
            4'd4:       base = SS_4;
            4'd5:       base = SS_5;
            4'd6:       base = SS_6;
            4'd7:       base = SS_7;
            4'd8:       base = SS_8;
            4'd9:       base = SS_9;
            CODE_A:     base = SS_A;
            CODE_MINUS: base = SS_MINUS;
            CODE_M:     base = SS_M;
            CODE_F:     base = SS_F;
            default:    base = SS_BLANK;
        endcase
    end

    // dp segment is bit 0 and active-low, so a request clears it
    assign seg = {base[7:1], base[0] & ~dp};

endmodule

// File: rtl/ssd_scan_display.sv
// rtl/ssd_scan_display.sv - time-multiplexed seven-segment scan driver
// Purpose: hold a loaded frame in a shadow register and scan NUM_DIGITS digits,
//          each lit for REFRESH_DIV cycles. Optional macro SSD_LEADING_ZERO_BLANK_EN
//          darkens leading zeros.
// Ports: clk, rst_n (async active-low); load, digits_in, dp_in (frame capture);
//        blank (force dark); ssd_ctl (segments, active-low); ssd_an (anodes,
//        active-low); frame_tick (pulse on scan wrap to digit 0).
module ssd_scan_display
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank,
    output logic [7:0]              ssd_ctl,
    output logic [NUM_DIGITS-1:0]   ssd_an,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        refresh_cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow_codes;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic                    cnt_wrap;
    logic [3:0]              sel_code;
    logic                    sel_dp;
    logic [7:0]              sel_seg;
    logic                    sel_lz;

    assign cnt_wrap = (refresh_cnt == CNT_LAST);
    assign sel_code = shadow_codes[4*int'(idx) +: 4];
    assign sel_dp   = shadow_dp[idx];

    ssd_glyph_decode u_decode (
        .code (sel_code),
        .dp   (sel_dp),
        .seg  (sel_seg)
    );

`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  upper_clear;
    logic [3:0]            code_i;

    // Walk from the most significant digit down; a digit stays a leading-zero
    // candidate only while every digit above it is dark (zero or blank code, no dp).
    always_comb begin
        lz_mask     = '0;
        upper_clear = 1'b1;
        code_i      = 4'h0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            code_i     = shadow_codes[4*i +: 4];
            lz_mask[i] = (i > 0) && upper_clear && (code_i == 4'd0) && !shadow_dp[i];
            upper_clear = upper_clear && !shadow_dp[i]
                          && ((code_i == 4'd0) || (code_i >= 4'd14));
        end
    end

    assign sel_lz = lz_mask[idx];
`else
    assign sel_lz = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt  <= '0;
            idx          <= '0;
            shadow_codes <= {NUM_DIGITS{CODE_BLANK}};
            shadow_dp    <= '0;
            ssd_ctl      <= SS_BLANK;
            ssd_an       <= '1;
            frame_tick   <= 1'b0;
        end else begin
            if (load) begin
                shadow_codes <= digits_in;
                shadow_dp    <= dp_in;
            end

            if (cnt_wrap) begin
                refresh_cnt <= '0;
                idx         <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end

            frame_tick <= cnt_wrap && (idx == IDX_LAST);

            // Outputs use the pre-edge idx/shadow, giving a fixed one-cycle latency
            // so every digit is lit for exactly REFRESH_DIV cycles.
            if (blank) begin
                ssd_an  <= '1;
                ssd_ctl <= SS_BLANK;
            end else begin
                ssd_an  <= ~(NUM_DIGITS'(1) << idx);
                ssd_ctl <= sel_lz ? SS_BLANK : sel_seg;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_display.sv
// tb/tb_ssd_scan_display.sv - self-checking bench for ssd_scan_display (4 digits, divide by 4)
module tb_ssd_scan_display;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank;
    logic [7:0]  ssd_ctl;
    logic [3:0]  ssd_an;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [31:0] exp;   // expected pattern of digit d in exp[8*d +: 8]
    } vec_t;

    vec_t tbl [5];

    ssd_scan_display #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank      (blank),
        .ssd_ctl    (ssd_ctl),
        .ssd_an     (ssd_an),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // sample k after release reflects the digit selected before edge k
    function automatic logic [3:0] exp_an(input int c);
        int d;
        d = ((c - 1) / 4) % 4;
        return ~(4'b0001 << d);
    endfunction

    function automatic logic [7:0] exp_byte(input logic [31:0] e, input int c);
        int d;
        d = ((c - 1) / 4) % 4;
        return e[8*d +: 8];
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        tbl[0] = '{16'h12AB, 4'b0000, {8'h9F, 8'h25, 8'h11, 8'hFD}};
`ifdef SSD_LEADING_ZERO_BLANK_EN
        tbl[1] = '{16'h0705, 4'b0010, {8'hFF, 8'h1F, 8'h02, 8'h49}};
        tbl[4] = '{16'h0000, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
`else
        tbl[1] = '{16'h0705, 4'b0010, {8'h03, 8'h1F, 8'h02, 8'h49}};
        tbl[4] = '{16'h0000, 4'b0000, {8'h03, 8'h03, 8'h03, 8'h03}};
`endif
        tbl[2] = '{16'h89CD, 4'b1001, {8'h00, 8'h09, 8'h91, 8'h70}};
        tbl[3] = '{16'hFE64, 4'b0000, {8'hFF, 8'hFF, 8'h41, 8'h99}};

        rst_n     = 1'b0;
        load      = 1'b0;
        blank     = 1'b0;
        digits_in = '0;
        dp_in     = '0;
        repeat (2) @(negedge clk);
        chk("reset_ctl", ssd_ctl, 8'hFF);
        chk("reset_an", ssd_an, 4'hF);
        chk("reset_tick", frame_tick, 1'b0);

        // idle scan: blank glyphs, anodes E,D,B,7, one tick per 16 cycles
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            chk("idle_an", ssd_an, exp_an(cyc));
            chk("idle_ctl", ssd_ctl, 8'hFF);
            chk("idle_tick", frame_tick, (cyc % 16 == 0) ? 1'b1 : 1'b0);
        end

        // glyph table: load one frame, then watch a full scan
        for (int v = 0; v < 5; v++) begin
            load      = 1'b1;
            digits_in = tbl[v].digits;
            dp_in     = tbl[v].dp;
            step();
            load = 1'b0;
            for (int k = 0; k < 16; k++) begin
                step();
                chk("glyph_an", ssd_an, exp_an(cyc));
                chk("glyph_ctl", ssd_ctl, exp_byte(tbl[v].exp, cyc));
            end
        end

        // blank mid-digit for 6 edges; scan phase must not slip
        while (cyc % 4 != 2) step();
        blank = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("blank_an", ssd_an, 4'hF);
            chk("blank_ctl", ssd_ctl, 8'hFF);
        end
        blank = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("unblank_an", ssd_an, exp_an(cyc));
            chk("unblank_ctl", ssd_ctl, exp_byte(tbl[4].exp, cyc));
        end

        // load coinciding with the idx advance
        load      = 1'b1;
        digits_in = 16'h8888;
        dp_in     = 4'b0000;
        step();
        load = 1'b0;
        while (cyc % 4 != 3) step();
        load      = 1'b1;
        digits_in = 16'h3333;
        step();
        load = 1'b0;
        chk("adv_old_an", ssd_an, exp_an(cyc));
        chk("adv_old_ctl", ssd_ctl, 8'h01);
        step();
        chk("adv_new_an", ssd_an, exp_an(cyc));
        chk("adv_new_ctl", ssd_ctl, 8'h0D);

        // asynchronous reset mid-frame
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("async_ctl", ssd_ctl, 8'hFF);
        chk("async_an", ssd_an, 4'hF);
        chk("async_tick", frame_tick, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            chk("post_rst_an", ssd_an, exp_an(cyc));
            chk("post_rst_ctl", ssd_ctl, 8'hFF);
            chk("post_rst_tick", frame_tick, (cyc == 16) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
